// File: rtl/lfsr32_checker.sv
// rtl/lfsr32_checker.sv - receive-side LFSR pattern checker for DDR3 read-back data
//
// Purpose: regenerates the 32-bit XNOR LFSR sequence, locks onto incoming
// read data, flags/counts mismatching words, captures the first failure
// and reports loss of sync.
//
// Optional build macro: LFSR32_CHK_BITCNT_EN adds the bit_err_count output.
//
// Ports:
//   clk            clock
//   reset          synchronous active-high reset
//   clear          synchronous restart (counters, captures, sticky flags)
//   enable         checker active; low returns to IDLE
//   din_valid      din carries a read word this cycle
//   din            read-back data word
//   locked         checker is in LOCKED
//   err_flag       one-cycle pulse per mismatching word while LOCKED
//   err_count      saturating count of mismatching words
//   first_err_data din of the first mismatch since reset/clear
//   first_err_exp  expected word of that first mismatch
//   sync_lost      sticky loss-of-sync indication
//   bit_err_count  (LFSR32_CHK_BITCNT_EN only) saturating mismatching-bit count

module lfsr32_checker #(
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 8,
  parameter int SELF_SYNC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 din_valid,
  input  logic [31:0]          din,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          first_err_data,
  output logic [31:0]          first_err_exp,
`ifdef LFSR32_CHK_BITCNT_EN
  output logic                 sync_lost,
  output logic [31:0]          bit_err_count
`else
  output logic                 sync_lost
`endif
);

  localparam logic [31:0] SEED   = 32'h9acedfba;
  localparam logic [7:0]  LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0]  LOSS_C = 8'(LOSS_CNT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    logic [31:0] n;
    for (int i = 0; i < 28; i++) n[i] = ~(q[i+1] ^ q[i+4]);
    n[28] = ~(q[1] ^ q[4] ^ q[29]);
    n[29] = ~(q[2] ^ q[5] ^ q[30]);
    n[30] = ~(q[3] ^ q[6] ^ q[31]);
    n[31] = ~(q[1] ^ q[7]);
    return n;
  endfunction

  state_e                 state_q;
  logic [31:0]            exp_q;
  logic [7:0]             mcnt_q;
  logic [7:0]             miss_q;
  logic                   acq_first_q;
  logic                   have_err_q;
  logic                   locked_q;
  logic                   err_flag_q;
  logic                   sync_lost_q;
  logic [ERR_CNT_W-1:0]   err_count_q;
  logic [ERR_CNT_W-1:0]   err_count_d;
  logic [31:0]            first_data_q;
  logic [31:0]            first_exp_q;

  logic [31:0] exp_next;
  logic [31:0] din_next;
  logic        mismatch;
  logic        locked_rules;

  assign exp_next = lfsr_next(exp_q);
  assign din_next = lfsr_next(din);
  assign mismatch = (din != exp_q);
  // Without self-sync, the first word in ACQUIRE is already judged against the seed.
  assign locked_rules = (state_q == ST_LOCKED) || (SELF_SYNC == 0);
  assign err_count_d = (err_count_q == {ERR_CNT_W{1'b1}}) ? err_count_q
                                                          : err_count_q + ERR_CNT_W'(1);

`ifdef LFSR32_CHK_BITCNT_EN
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  logic [31:0] bit_err_q;
  logic [31:0] bit_err_d;
  logic [32:0] bit_sum;

  assign bit_sum   = {1'b0, bit_err_q} + {27'd0, popcount32(din ^ exp_q)};
  assign bit_err_d = bit_sum[32] ? 32'hffff_ffff : bit_sum[31:0];
  assign bit_err_count = bit_err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      // clear behaves like reset but may go straight to ACQUIRE
      state_q      <= (!reset && enable) ? ST_ACQUIRE : ST_IDLE;
      exp_q        <= SEED;
      mcnt_q       <= '0;
      miss_q       <= '0;
      acq_first_q  <= 1'b1;
      have_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      sync_lost_q  <= 1'b0;
      err_count_q  <= '0;
      first_data_q <= '0;
      first_exp_q  <= '0;
`ifdef LFSR32_CHK_BITCNT_EN
      bit_err_q    <= '0;
`endif
    end else begin
      err_flag_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          exp_q       <= SEED;
          mcnt_q      <= '0;
          miss_q      <= '0;
          acq_first_q <= 1'b1;
          if (enable) state_q <= ST_ACQUIRE;
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (din_valid) begin
            if (locked_rules) begin
              exp_q    <= exp_next;
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              if (mismatch) begin
                err_flag_q  <= 1'b1;
                err_count_q <= err_count_d;
`ifdef LFSR32_CHK_BITCNT_EN
                bit_err_q   <= bit_err_d;
`endif
                if (!have_err_q) begin
                  have_err_q   <= 1'b1;
                  first_data_q <= din;
                  first_exp_q  <= exp_q;
                end
                if (miss_q + 8'd1 == LOSS_C) begin
                  sync_lost_q <= 1'b1;
                  locked_q    <= 1'b0;
                  state_q     <= ST_ACQUIRE;
                  miss_q      <= '0;
                  mcnt_q      <= '0;
                  acq_first_q <= 1'b1;
                  if (SELF_SYNC == 0) exp_q <= SEED;
                end else begin
                  miss_q <= miss_q + 8'd1;
                end
              end else begin
                miss_q <= '0;
              end
            end else if (acq_first_q) begin
              // seed the local generator from the received word
              exp_q       <= din_next;
              mcnt_q      <= '0;
              acq_first_q <= 1'b0;
            end else if (!mismatch) begin
              exp_q <= exp_next;
              if (mcnt_q + 8'd1 == LOCK_C) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                mcnt_q   <= '0;
                miss_q   <= '0;
              end else begin
                mcnt_q <= mcnt_q + 8'd1;
              end
            end else begin
              exp_q  <= din_next;
              mcnt_q <= '0;
            end
          end
          // the current word was handled above; leaving keeps counts and flags
          if (!enable) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign locked         = locked_q;
  assign err_flag       = err_flag_q;
  assign err_count      = err_count_q;
  assign first_err_data = first_data_q;
  assign first_err_exp  = first_exp_q;
  assign sync_lost      = sync_lost_q;

endmodule

// File: tb/tb_lfsr32_checker.sv
// tb/tb_lfsr32_checker.sv - directed self-checking bench for lfsr32_checker

module tb_lfsr32_checker;

  localparam logic [31:0] SEED = 32'h9acedfba;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        enable;
  logic        din_valid;
  logic [31:0] din;

  // u0: SELF_SYNC=0; u1: SELF_SYNC=1; u4: SELF_SYNC=1 with 4-bit error counter
  logic        locked0, err_flag0, sync_lost0;
  logic [15:0] err_count0;
  logic [31:0] fdata0, fexp0;
  logic        locked1, err_flag1, sync_lost1;
  logic [15:0] err_count1;
  logic [31:0] fdata1, fexp1;
  logic        locked4, err_flag4, sync_lost4;
  logic [3:0]  err_count4;
  logic [31:0] fdata4, fexp4;
`ifdef LFSR32_CHK_BITCNT_EN
  logic [31:0] bitcnt0, bitcnt1, bitcnt4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  lfsr32_checker #(.SELF_SYNC(0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .din_valid(din_valid), .din(din),
    .locked(locked0), .err_flag(err_flag0), .err_count(err_count0),
    .first_err_data(fdata0), .first_err_exp(fexp0),
`ifdef LFSR32_CHK_BITCNT_EN
    .bit_err_count(bitcnt0),
`endif
    .sync_lost(sync_lost0)
  );

  lfsr32_checker #(.SELF_SYNC(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .din_valid(din_valid), .din(din),
    .locked(locked1), .err_flag(err_flag1), .err_count(err_count1),
    .first_err_data(fdata1), .first_err_exp(fexp1),
`ifdef LFSR32_CHK_BITCNT_EN
    .bit_err_count(bitcnt1),
`endif
    .sync_lost(sync_lost1)
  );

  lfsr32_checker #(.SELF_SYNC(1), .ERR_CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .din_valid(din_valid), .din(din),
    .locked(locked4), .err_flag(err_flag4), .err_count(err_count4),
    .first_err_data(fdata4), .first_err_exp(fexp4),
`ifdef LFSR32_CHK_BITCNT_EN
    .bit_err_count(bitcnt4),
`endif
    .sync_lost(sync_lost4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] gen_next(input logic [31:0] q);
    logic [31:0] n;
    for (int i = 0; i < 28; i++) n[i] = ~(q[i+1] ^ q[i+4]);
    n[28] = ~(q[1] ^ q[4] ^ q[29]);
    n[29] = ~(q[2] ^ q[5] ^ q[30]);
    n[30] = ~(q[3] ^ q[6] ^ q[31]);
    n[31] = ~(q[1] ^ q[7]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle from a negedge; on return the outputs reflect that cycle
  task automatic step(input logic v, input logic [31:0] d);
    din_valid = v;
    din = d;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 32'h0);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] g;
    logic [31:0] w10;
    logic        flag_seen;

    reset = 1'b1; clear = 1'b0; enable = 1'b0; din_valid = 1'b0; din = '0;
    @(negedge clk);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    reset = 1'b0;
    step(1'b0, 32'h0);

    check("rst_locked", locked0, 0);
    check("rst_err_flag", err_flag0, 0);
    check("rst_err_count", err_count0, 0);
    check("rst_first_data", fdata0, 0);
    check("rst_first_exp", fexp0, 0);
    check("rst_sync_lost", sync_lost0, 0);

    // fixed-seed checker: lock on word 0, no errors over 20 words
    enable = 1'b1;
    step(1'b0, 32'h0);
    g = SEED;
    flag_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, g);
      if (i == 0) check("ss0_lock_w0", locked0, 1);
      flag_seen = flag_seen | err_flag0;
      g = gen_next(g);
    end
    check("ss0_err_count", err_count0, 0);
    check("ss0_no_flag", flag_seen, 0);

    // self-sync checker from a stream advanced 37 steps
    do_clear();
    g = SEED;
    for (int i = 0; i < 37; i++) g = gen_next(g);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, g);
      if (i == 3) check("ss1_unlocked_w3", locked1, 0);
      if (i == 4) check("ss1_locked_w4", locked1, 1);
      g = gen_next(g);
    end
    check("ss1_err_count", err_count1, 0);

    // single-bit error on word 10, clean word 11
    w10 = g;
    step(1'b1, g ^ 32'h0000_0020);
    g = gen_next(g);
    check("bit5_flag", err_flag1, 1);
    check("bit5_count", err_count1, 1);
    check("bit5_first_exp", fexp1, w10);
    check("bit5_first_data", fdata1, w10 ^ 32'h0000_0020);
    step(1'b1, g);
    g = gen_next(g);
    check("w11_flag", err_flag1, 0);
    check("w11_count", err_count1, 1);

    // 8 consecutive bad words force loss of sync
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ~g);
      if (i == 6) check("loss_still_locked", locked1, 1);
      g = gen_next(g);
    end
    check("loss_sync_lost", sync_lost1, 1);
    check("loss_locked", locked1, 0);
    check("loss_err_count", err_count1, 9);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g);
      if (i == 3) check("relock_w3", locked1, 0);
      g = gen_next(g);
    end
    check("relock_locked", locked1, 1);
    check("relock_sticky", sync_lost1, 1);

    // clear drops sticky state; then saturate the 4-bit counter
    do_clear();
    check("clr_sync_lost", sync_lost1, 0);
    check("clr_err_count", err_count1, 0);
    check("clr_first_data", fdata1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g);
      g = gen_next(g);
    end
    check("sat_locked", locked4, 1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, g ^ 32'h0000_0001);
      g = gen_next(g);
      step(1'b1, g);
      g = gen_next(g);
    end
    check("sat_count4", err_count4, 4'hF);
    check("sat_count16", err_count1, 20);
    check("sat_still_locked", locked4, 1);

    // enable drop: word still processed, then IDLE with counts kept
    enable = 1'b0;
    step(1'b1, g);
    g = gen_next(g);
    check("en_drop_locked", locked1, 0);
    check("en_drop_count", err_count1, 20);
    step(1'b0, 32'h0);

    do_clear();
    check("clr4_err_count", err_count4, 0);
    check("clr4_sync_lost", sync_lost4, 0);
    check("clr4_first_data", fdata4, 0);
    check("clr4_first_exp", fexp4, 0);

`ifdef LFSR32_CHK_BITCNT_EN
    enable = 1'b1;
    step(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g);
      g = gen_next(g);
    end
    check("bc_locked", locked1, 1);
    step(1'b1, g ^ 32'h8000_0081);
    g = gen_next(g);
    check("bc_bit_count", bitcnt1, 3);
    check("bc_err_count", err_count1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
